// File: rtl/scoreboard_hazard_unit_if.sv
// Hazard handshake between ID/WB/EX (master side) and the scoreboard hazard unit (slave side).
// Carries the decode-stage register names, retire/redirect events, and the stall/flush/status results.
interface scoreboard_hazard_unit_if #(
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [4:0]       id_rs1_addr;
   logic [4:0]       id_rs2_addr;
   logic [4:0]       id_rd_addr;
   logic             id_reg_write;
   logic             wb_reg_write;
   logic [4:0]       wb_rd_addr;
   logic             ex_redirect;
   logic             stall;
   logic             flush;
   logic [31:0]      pending_mask;
   logic [CNT_W-1:0] stall_count;
   logic             sb_overflow;

   modport master (
      output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_reg_write,
      output wb_reg_write, wb_rd_addr, ex_redirect,
      input  stall, flush, pending_mask, stall_count, sb_overflow
   );

   modport slave (
      input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_reg_write,
      input  wb_reg_write, wb_rd_addr, ex_redirect,
      output stall, flush, pending_mask, stall_count, sb_overflow
   );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Per-register in-flight write scoreboard driving stall/flush into ID; stall and flush are
// combinational (zero latency), scoreboard updates are seen one cycle after the edge; stall is the backpressure.
module scoreboard_hazard_unit #(
   parameter int PEND_W       = 2,
   parameter int FLUSH_CYCLES = 1,
   parameter int BYPASS_WB    = 1,
   parameter int CNT_W        = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   scoreboard_hazard_unit_if.slave sb
);
   localparam logic [PEND_W-1:0] CNT_MAX   = '1;
   localparam logic [PEND_W-1:0] CNT_ONE   = PEND_W'(1);
   localparam logic [2:0]        HOLD_INIT = 3'(FLUSH_CYCLES - 1);

   logic [PEND_W-1:0] cnt [32];
   logic [2:0]        hold;
   logic [CNT_W-1:0]  stall_cnt;
   logic              ovf;

   logic [31:0] nz_vec, one_vec, full_vec, inc_vec, dec_vec;
   logic        haz1, haz2, flush_i, stall_i, issue;

   // Bit 0 of every vector stays clear so x0 is never tracked.
   always_comb begin
      nz_vec   = '0;
      one_vec  = '0;
      full_vec = '0;
      for (int i = 1; i < 32; i++) begin
         nz_vec[i]   = (cnt[i] != '0);
         one_vec[i]  = (cnt[i] == CNT_ONE);
         full_vec[i] = (cnt[i] == CNT_MAX);
      end
   end

   always_comb begin
      haz1 = nz_vec[sb.id_rs1_addr] &&
             !((BYPASS_WB != 0) && sb.wb_reg_write &&
               (sb.wb_rd_addr == sb.id_rs1_addr) && one_vec[sb.id_rs1_addr]);
      haz2 = nz_vec[sb.id_rs2_addr] &&
             !((BYPASS_WB != 0) && sb.wb_reg_write &&
               (sb.wb_rd_addr == sb.id_rs2_addr) && one_vec[sb.id_rs2_addr]);
      flush_i = reset && (sb.ex_redirect || (hold != '0));
      stall_i = reset && sb.id_valid && !flush_i && (haz1 || haz2);
      issue   = sb.id_valid && !stall_i && !flush_i;
      inc_vec = (issue && sb.id_reg_write) ? ((32'd1 << sb.id_rd_addr) & ~32'd1) : '0;
      dec_vec = sb.wb_reg_write ? ((32'd1 << sb.wb_rd_addr) & ~32'd1) : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) cnt[i] <= '0;
         hold      <= '0;
         stall_cnt <= '0;
         ovf       <= 1'b0;
      end else begin
         // Issue and retire on the same register cancel out.
         for (int i = 0; i < 32; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
               if (!full_vec[i]) cnt[i] <= cnt[i] + CNT_ONE;
            end else if (dec_vec[i] && !inc_vec[i] && nz_vec[i]) begin
               cnt[i] <= cnt[i] - CNT_ONE;
            end
         end
         if (|(inc_vec & ~dec_vec & full_vec)) ovf <= 1'b1;
         if (sb.ex_redirect)    hold <= HOLD_INIT;
         else if (hold != '0)   hold <= hold - 3'd1;
         if (stall_i && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign sb.stall        = stall_i;
   assign sb.flush        = flush_i;
   assign sb.pending_mask = reset ? nz_vec : '0;
   assign sb.stall_count  = stall_cnt;
   assign sb.sb_overflow  = ovf;
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench: dut_a uses write-before-read bypass and a 2-cycle flush, dut_b has no bypass.
module tb_scoreboard_hazard_unit;
   logic clk;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   scoreboard_hazard_unit_if #(.CNT_W(32)) ia ();
   scoreboard_hazard_unit_if #(.CNT_W(32)) ib ();

   scoreboard_hazard_unit #(.PEND_W(2), .FLUSH_CYCLES(2), .BYPASS_WB(1), .CNT_W(32)) dut_a (
      .clk(clk), .reset(reset), .sb(ia));
   scoreboard_hazard_unit #(.PEND_W(2), .FLUSH_CYCLES(1), .BYPASS_WB(0), .CNT_W(32)) dut_b (
      .clk(clk), .reset(reset), .sb(ib));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic w, input logic wbw,
                        input logic [4:0] wbrd, input logic red);
      ia.id_valid     = v;
      ia.id_rs1_addr  = rs1;
      ia.id_rs2_addr  = rs2;
      ia.id_rd_addr   = rd;
      ia.id_reg_write = w;
      ia.wb_reg_write = wbw;
      ia.wb_rd_addr   = wbrd;
      ia.ex_redirect  = red;
   endtask

   task automatic drv_b(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic w, input logic wbw,
                        input logic [4:0] wbrd, input logic red);
      ib.id_valid     = v;
      ib.id_rs1_addr  = rs1;
      ib.id_rs2_addr  = rs2;
      ib.id_rd_addr   = rd;
      ib.id_reg_write = w;
      ib.wb_reg_write = wbw;
      ib.wb_rd_addr   = wbrd;
      ib.ex_redirect  = red;
   endtask

   initial begin
      reset = 1'b0;
      drv_a(0, 0, 0, 0, 0, 0, 0, 1);
      drv_b(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_flush_a", ia.flush, 0);
      chk("rst_stall_a", ia.stall, 0);
      chk("rst_mask_a", ia.pending_mask, 0);
      chk("rst_cnt_a", ia.stall_count, 0);
      chk("rst_ovf_a", ia.sb_overflow, 0);
      chk("rst_mask_b", ib.pending_mask, 0);
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      #6 reset = 1'b1;
      nxt();

      // RAW on x5 with bypass: stalls two cycles, retire cycle resolves it
      drv_a(1, 0, 0, 5, 1, 0, 0, 0); #1; chk("a_issue_nostall", ia.stall, 0); nxt();
      drv_a(1, 5, 0, 0, 0, 0, 0, 0); #1; chk("a_raw_stall1", ia.stall, 1);
      chk("a_mask5", ia.pending_mask, 32'h20); nxt();
      #1; chk("a_raw_stall2", ia.stall, 1); nxt();
      drv_a(1, 5, 0, 0, 0, 1, 5, 0); #1; chk("a_bypass_release", ia.stall, 0); nxt();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0); #1; chk("a_stall_count2", ia.stall_count, 2);
      chk("a_mask_clear", ia.pending_mask, 0);

      // same flow without bypass: stall persists through the retire cycle
      drv_b(1, 0, 0, 5, 1, 0, 0, 0); nxt();
      drv_b(1, 5, 0, 0, 0, 0, 0, 0); #1; chk("b_raw_stall", ib.stall, 1); nxt();
      nxt();
      drv_b(1, 5, 0, 0, 0, 1, 5, 0); #1; chk("b_nobypass_stall", ib.stall, 1); nxt();
      drv_b(1, 5, 0, 0, 0, 0, 0, 0); #1; chk("b_release", ib.stall, 0);
      chk("b_stall_count3", ib.stall_count, 3); nxt();
      drv_b(0, 0, 0, 0, 0, 0, 0, 0);

      // two writes in flight to x7
      drv_a(1, 0, 0, 7, 1, 0, 0, 0); #1; chk("c_issue1", ia.stall, 0); nxt();
      drv_a(1, 0, 0, 7, 1, 0, 0, 0); #1; chk("c_issue2", ia.stall, 0); nxt();
      drv_a(1, 0, 7, 0, 0, 1, 7, 0); #1; chk("c_cnt2_stall", ia.stall, 1);
      chk("c_mask7", ia.pending_mask, 32'h80); nxt();
      drv_a(1, 0, 7, 0, 0, 0, 0, 0); #1; chk("c_cnt1_stall", ia.stall, 1); nxt();
      drv_a(1, 0, 7, 0, 0, 1, 7, 0); #1; chk("c_second_retire", ia.stall, 0); nxt();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0); #1; chk("c_mask_clear", ia.pending_mask, 0);
      chk("c_stall_count4", ia.stall_count, 4);

      // redirect while stalled on x3; reader also writes x9 and must not issue
      drv_a(1, 0, 0, 3, 1, 0, 0, 0); nxt();
      drv_a(1, 3, 0, 9, 1, 0, 0, 0); #1; chk("d_stall", ia.stall, 1);
      chk("d_noflush", ia.flush, 0); nxt();
      drv_a(1, 3, 0, 9, 1, 0, 0, 1); #1; chk("d_flush1", ia.flush, 1);
      chk("d_flush1_nostall", ia.stall, 0); nxt();
      drv_a(1, 3, 0, 9, 1, 0, 0, 0); #1; chk("d_flush2", ia.flush, 1);
      chk("d_flush2_nostall", ia.stall, 0); nxt();
      #1; chk("d_flush_end", ia.flush, 0); chk("d_restall", ia.stall, 1);
      chk("d_mask_no9", ia.pending_mask, 32'h08); chk("d_stall_count5", ia.stall_count, 5); nxt();
      drv_a(0, 0, 0, 0, 0, 1, 3, 0); nxt();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0); #1; chk("d_mask_clear", ia.pending_mask, 0);
      chk("d_stall_count6", ia.stall_count, 6);

      // x0 never tracked; retire of an idle register is ignored
      drv_a(1, 0, 0, 0, 1, 0, 0, 0); #1; chk("e_x0_nostall", ia.stall, 0); nxt();
      drv_a(1, 0, 0, 0, 0, 1, 9, 0); #1; chk("e_x0_mask", ia.pending_mask, 0);
      chk("e_x0_read", ia.stall, 0); nxt();
      drv_a(1, 9, 0, 0, 0, 0, 0, 0); #1; chk("e_no_wrap", ia.stall, 0);
      chk("e_mask_zero", ia.pending_mask, 0); nxt();

      // saturate x4, then reset asynchronously mid-cycle
      for (int k = 0; k < 3; k++) begin
         drv_a(1, 0, 0, 4, 1, 0, 0, 0); nxt();
      end
      drv_a(0, 0, 0, 0, 0, 0, 0, 0); #1; chk("f_no_ovf_at3", ia.sb_overflow, 0);
      chk("f_mask4", ia.pending_mask, 32'h10);
      drv_a(1, 0, 0, 4, 1, 0, 0, 0); nxt();
      drv_a(1, 4, 0, 0, 0, 0, 0, 0); #1; chk("f_ovf", ia.sb_overflow, 1);
      chk("f_sat_stall", ia.stall, 1); chk("f_mask4_sat", ia.pending_mask, 32'h10);
      drv_a(1, 4, 0, 0, 0, 0, 0, 1); #1; chk("f_flush", ia.flush, 1);
      reset = 1'b0; #1;
      chk("f_rst_stall", ia.stall, 0);
      chk("f_rst_flush", ia.flush, 0);
      chk("f_rst_mask", ia.pending_mask, 0);
      chk("f_rst_count", ia.stall_count, 0);
      chk("f_rst_ovf", ia.sb_overflow, 0);
      drv_a(1, 4, 0, 0, 0, 0, 0, 0);
      #1 reset = 1'b1;
      nxt();
      #1; chk("f_post_mask", ia.pending_mask, 0); chk("f_post_stall", ia.stall, 0);
      chk("f_post_flush", ia.flush, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
